// File: rtl/clock_enable_generator_if.sv
// clock_enable_generator_if: byte-serial configuration bus with commit acknowledge/error pulses.
interface clock_enable_generator_if #(
   parameter int DATA_WIDTH = 8,
   parameter int SELECT_WIDTH = 3
);
   logic [DATA_WIDTH-1:0] conf_bus;
   logic [SELECT_WIDTH-1:0] sel;
   logic conf_ack;
   logic conf_err;
   modport master (output conf_bus, sel, input conf_ack, conf_err);
   modport slave (input conf_bus, sel, output conf_ack, conf_err);
endinterface

// File: rtl/clock_enable_generator.sv
// clock_enable_generator: per-channel tick enables with byte-serially programmed dividers and lock detect.
// Optional PHASE_OFFSET_EN: each command also carries a phase preload for its tick counter.
module clock_enable_generator #(
   parameter int NUM_CHANNELS = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ITERATION_VARIABLE_WIDTH = 16,
   parameter int SELECT_WIDTH = 3,
   parameter logic [SELECT_WIDTH-1:0] SELECT_ID = SELECT_WIDTH'(1),
   parameter int SETTLE_CYCLES = 8
) (
   input logic clkin_in,
   input logic reset_n,
   clock_enable_generator_if.slave cfg,
   output logic [NUM_CHANNELS*ITERATION_VARIABLE_WIDTH-1:0] div_reg,
   output logic [NUM_CHANNELS-1:0] tick,
   output logic locked_out
);
   localparam int W = ITERATION_VARIABLE_WIDTH;
   localparam int BYTES = (W + DATA_WIDTH - 1) / DATA_WIDTH;
`ifdef PHASE_OFFSET_EN
   localparam int NV = 2 * BYTES;
`else
   localparam int NV = BYTES;
`endif
   localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
   localparam int BW = NV > 1 ? $clog2(NV) : 1;
   localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [DATA_WIDTH-1:0] NC = DATA_WIDTH'(NUM_CHANNELS);
   typedef enum logic [1:0] {IDLE, LOAD_VAL, COMMIT} cfg_state_t;
   typedef enum logic [1:0] {UNLOCKED, SETTLE, LOCKED} lock_state_t;
   cfg_state_t cstate;
   lock_state_t lstate;
   logic [CW-1:0] ch;
   logic oor;
   logic [BW-1:0] byte_cnt;
   logic [NV*DATA_WIDTH-1:0] shadow, shadow_nxt;
   logic [NUM_CHANNELS-1:0] programmed;
   logic [SW-1:0] settle_cnt;
   logic [NUM_CHANNELS-1:0][W-1:0] cnt, start;
   logic strobe, last, commit_ok;
   assign strobe = cfg.sel == SELECT_ID;
   assign last = cstate == LOAD_VAL && strobe && byte_cnt == BW'(NV - 1);
   assign commit_ok = last && !oor;
   always_comb begin
      shadow_nxt = shadow;
      for (int b = 0; b < NV; b++)
         if (byte_cnt == BW'(b)) shadow_nxt[b*DATA_WIDTH +: DATA_WIDTH] = cfg.conf_bus;
   end
`ifdef PHASE_OFFSET_EN
   logic [NUM_CHANNELS-1:0][W-1:0] phase_reg;
   logic enter_lock;
   assign enter_lock = lstate == SETTLE && settle_cnt == '0 && !commit_ok;
   // a phase at or beyond the divider would skip the wrap point, so it starts from 0
   always_comb begin
      start = '0;
      for (int c = 0; c < NUM_CHANNELS; c++)
         start[c] = (enter_lock && phase_reg[c] < div_reg[c*W +: W]) ? phase_reg[c] : '0;
   end
   always_ff @(posedge clkin_in or negedge reset_n)
      if (!reset_n) phase_reg <= '0;
      else if (commit_ok)
         for (int c = 0; c < NUM_CHANNELS; c++)
            if (CW'(c) == ch) phase_reg[c] <= shadow_nxt[BYTES*DATA_WIDTH +: W];
`else
   assign start = '0;
`endif
   // the commit side effects land on the edge entering COMMIT so conf_ack is high during COMMIT
   always_ff @(posedge clkin_in or negedge reset_n)
      if (!reset_n) begin
         cstate <= IDLE;
         ch <= '0;
         oor <= 1'b0;
         byte_cnt <= '0;
         shadow <= '0;
         div_reg <= '0;
         programmed <= '0;
         cfg.conf_ack <= 1'b0;
         cfg.conf_err <= 1'b0;
      end else begin
         cfg.conf_ack <= 1'b0;
         cfg.conf_err <= 1'b0;
         if (cstate == IDLE && strobe) begin
            ch <= cfg.conf_bus[CW-1:0];
            oor <= cfg.conf_bus >= NC;
            byte_cnt <= '0;
            cstate <= LOAD_VAL;
         end else if (cstate == LOAD_VAL && strobe) begin
            shadow <= shadow_nxt;
            byte_cnt <= byte_cnt + 1'b1;
            if (last) begin
               cstate <= COMMIT;
               cfg.conf_ack <= !oor;
               cfg.conf_err <= oor;
               for (int c = 0; c < NUM_CHANNELS; c++)
                  if (!oor && CW'(c) == ch) begin
                     div_reg[c*W +: W] <= shadow_nxt[W-1:0];
                     programmed[c] <= 1'b1;
                  end
            end
         end else if (cstate == COMMIT) cstate <= IDLE;
      end
   always_ff @(posedge clkin_in or negedge reset_n)
      if (!reset_n) begin
         lstate <= UNLOCKED;
         settle_cnt <= '0;
         locked_out <= 1'b0;
      end else if (commit_ok) begin
         lstate <= UNLOCKED;
         locked_out <= 1'b0;
      end else if (lstate == UNLOCKED && &programmed) begin
         lstate <= SETTLE;
         settle_cnt <= SW'(SETTLE_CYCLES - 1);
      end else if (lstate == SETTLE) begin
         if (settle_cnt == '0) begin
            lstate <= LOCKED;
            locked_out <= 1'b1;
         end else settle_cnt <= settle_cnt - 1'b1;
      end
   always_comb begin
      tick = '0;
      for (int c = 0; c < NUM_CHANNELS; c++)
         tick[c] = locked_out && div_reg[c*W +: W] != '0 && cnt[c] == div_reg[c*W +: W] - W'(1);
   end
   always_ff @(posedge clkin_in or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else
         for (int c = 0; c < NUM_CHANNELS; c++)
            cnt[c] <= (!locked_out || commit_ok) ? start[c] : tick[c] ? '0 : cnt[c] + 1'b1;
endmodule

// File: tb/tb_clock_enable_generator.sv
// tb_clock_enable_generator: directed programming, lock timing and tick pattern checks.
module tb_clock_enable_generator;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [63:0] div_reg;
   logic [3:0] tick;
   logic locked_out;
   int total = 0;
   int bad = 0;
   clock_enable_generator_if #(.DATA_WIDTH(8), .SELECT_WIDTH(3)) bus ();
   clock_enable_generator dut (
      .clkin_in(clk),
      .reset_n(reset_n),
      .cfg(bus),
      .div_reg(div_reg),
      .tick(tick),
      .locked_out(locked_out)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // drives one command; returns one cycle after the ack/err cycle
   task automatic cmd(input logic [7:0] idx, input logic [15:0] val, input logic err_exp, input string tag);
      @(negedge clk);
      bus.sel = 3'b001;
      bus.conf_bus = idx;
      @(negedge clk);
      bus.conf_bus = val[7:0];
      @(negedge clk);
      bus.conf_bus = val[15:8];
`ifdef PHASE_OFFSET_EN
      @(negedge clk);
      bus.conf_bus = 8'h00;
      @(negedge clk);
      bus.conf_bus = 8'h00;
`endif
      @(negedge clk);
      bus.sel = 3'b000;
      bus.conf_bus = 8'h00;
      check({tag, "_ack"}, 64'(bus.conf_ack), 64'(!err_exp));
      check({tag, "_err"}, 64'(bus.conf_err), 64'(err_exp));
      if (!err_exp) begin
         check({tag, "_unlock"}, 64'(locked_out), 64'd0);
         check({tag, "_tickoff"}, 64'(tick), 64'd0);
      end
      @(negedge clk);
      check({tag, "_ackclr"}, 64'(bus.conf_ack), 64'd0);
      check({tag, "_errclr"}, 64'(bus.conf_err), 64'd0);
   endtask
   task automatic wait_lock(input string tag);
      repeat (7) @(negedge clk);
      check({tag, "_prelock"}, 64'(locked_out), 64'd0);
      @(negedge clk);
      check({tag, "_lock"}, 64'(locked_out), 64'd1);
   endtask
   initial begin
      bus.sel = 3'b000;
      bus.conf_bus = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_div", div_reg, 64'd0);
      check("rst_ack", 64'(bus.conf_ack), 64'd0);
      check("rst_err", 64'(bus.conf_err), 64'd0);
      check("rst_tick", 64'(tick), 64'd0);
      check("rst_lock", 64'(locked_out), 64'd0);
      reset_n = 1'b1;
      cmd(8'h00, 16'd1, 1'b0, "ch0");
      cmd(8'h01, 16'd2, 1'b0, "ch1");
      cmd(8'h02, 16'd3, 1'b0, "ch2");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i % 5 == 4) begin
            check("partial_lock", 64'(locked_out), 64'd0);
            check("partial_tick", 64'(tick), 64'd0);
         end
      end
      cmd(8'h03, 16'd0, 1'b0, "ch3");
      wait_lock("first");
      check("div_all", div_reg, {16'd0, 16'd3, 16'd2, 16'd1});
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) @(negedge clk);
         check($sformatf("tick_a%0d", k), 64'(tick), 64'({1'b0, k % 3 == 0, k % 2 == 0, 1'b1}));
      end
      cmd(8'h07, 16'h1234, 1'b1, "oor");
      check("oor_div", div_reg, {16'd0, 16'd3, 16'd2, 16'd1});
      check("oor_lock", 64'(locked_out), 64'd1);
      cmd(8'h01, 16'd5, 1'b0, "rw1");
      check("rw_div", div_reg, {16'd0, 16'd3, 16'd5, 16'd1});
      wait_lock("relock");
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clk);
         check($sformatf("tick_b%0d", k), 64'(tick), 64'({1'b0, k % 3 == 0, k % 5 == 0, 1'b1}));
      end
      @(negedge clk);
      bus.sel = 3'b001;
      bus.conf_bus = 8'h02;
      @(negedge clk);
      bus.conf_bus = 8'h09;
      @(negedge clk);
      reset_n = 1'b0;
      bus.sel = 3'b000;
      bus.conf_bus = 8'h00;
      @(negedge clk);
      check("mid_div", div_reg, 64'd0);
      check("mid_lock", 64'(locked_out), 64'd0);
      check("mid_tick", 64'(tick), 64'd0);
      check("mid_ack", 64'(bus.conf_ack), 64'd0);
      reset_n = 1'b1;
      cmd(8'h00, 16'h0107, 1'b0, "post");
      check("post_div", div_reg, 64'h0107);
      repeat (12) @(negedge clk);
      check("post_lock", 64'(locked_out), 64'd0);
      check("post_tick", 64'(tick), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
